capture_controller: RTL

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

---
 rtl/capture_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/capture_controller.sv
// Trigger/capture sequencer for a circular sample buffer: pre-trigger fill,
// level/slope or forced trigger, post-trigger fill, then hold for display.
module capture_controller #(
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 10,
    parameter int PRETRIG    = 320
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sample_valid,
    input  logic [DATA_WIDTH-1:0]    i_sample,
    input  logic [DATA_WIDTH-1:0]    i_trig_level,
    input  logic                     i_trig_slope,
    input  logic                     i_single,
    input  logic                     i_arm,
    input  logic                     i_force,
    input  logic                     i_frame_done,
    output logic                     o_wr_en,
    output logic [$clog2(DEPTH)-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]    o_wr_data,
    output logic [$clog2(DEPTH)-1:0] o_base_addr,
    output logic                     o_buffer_ready,
    output logic                     o_triggered,
    output logic [2:0]               o_state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int POSTN = DEPTH - PRETRIG;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t                r_state, w_next;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_cnt;
    logic [AW-1:0]         r_trig_addr;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_force_pend;
    logic                  w_capture;
    logic                  w_trig;
    logic                  w_level_hit;

    // Oldest sample of the frame sits POSTN slots past the trigger, modulo DEPTH.
    function automatic logic [AW-1:0] f_base(input logic [AW-1:0] a);
        logic [AW:0] s;
        s = {1'b0, a} + (AW+1)'(POSTN);
        if (s >= (AW+1)'(DEPTH)) s = s - (AW+1)'(DEPTH);
        return s[AW-1:0];
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_trig      = 1'b0;
        w_capture   = 1'b0;
        w_level_hit = i_trig_slope ? (r_prev > i_trig_level && i_sample <= i_trig_level)
                                   : (r_prev < i_trig_level && i_sample >= i_trig_level);
        case (r_state)
            S_IDLE: if (i_arm) w_next = S_PREFILL;
            S_PREFILL: begin
                w_capture = i_sample_valid;
                if (i_sample_valid && r_cnt == AW'(PRETRIG-1)) w_next = S_ARMED;
            end
            S_ARMED: begin
                w_capture = i_sample_valid;
                if (i_sample_valid && (r_force_pend || i_force || w_level_hit)) begin
                    w_trig = 1'b1;
                    w_next = (POSTN == 1) ? S_HOLD : S_POST;
                end
            end
            S_POST: begin
                w_capture = i_sample_valid;
                if (i_sample_valid && r_cnt == AW'(POSTN-1)) w_next = S_HOLD;
            end
            S_HOLD: if (i_frame_done) w_next = i_single ? S_IDLE : S_PREFILL;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_triggered  <= 1'b0;
            o_base_addr  <= '0;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_trig_addr  <= '0;
            r_prev       <= '0;
            r_force_pend <= 1'b0;
        end else begin
            o_wr_en     <= w_capture;
            o_triggered <= w_trig;
            if (w_capture) begin
                o_wr_data <= i_sample;
                o_wr_addr <= r_wptr;
                r_prev    <= i_sample;
                r_wptr    <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
            end
            // One counter serves both fill phases; the trigger sample is post sample #1.
            if (w_next != r_state)
                r_cnt <= w_trig ? AW'(1) : '0;
            else if (w_capture && r_state != S_ARMED)
                r_cnt <= r_cnt + 1'b1;
            if (w_trig) r_trig_addr <= r_wptr;
            if (r_state == S_ARMED && w_next != S_ARMED) r_force_pend <= 1'b0;
            else if (r_state == S_ARMED && i_force)      r_force_pend <= 1'b1;
            if (w_next == S_HOLD && r_state != S_HOLD)
                o_base_addr <= f_base(w_trig ? r_wptr : r_trig_addr);
        end
    end

    assign o_buffer_ready = (r_state == S_HOLD);
    assign o_state        = r_state;

endmodule
